// File: rtl/sap1_pkg.sv
// Shared constants for the SAP-1 datapath: control-word bit positions,
// opcodes, the idle control word and a bus-driver counting helper.
package sap1_pkg;

    localparam int CON_W    = 12;
    localparam int CON_CP   = 11;
    localparam int CON_EP   = 10;
    localparam int CON_LM_N = 9;
    localparam int CON_CE_N = 8;
    localparam int CON_LI_N = 7;
    localparam int CON_EI_N = 6;
    localparam int CON_LA_N = 5;
    localparam int CON_EA   = 4;
    localparam int CON_SU   = 3;
    localparam int CON_EU   = 2;
    localparam int CON_LB_N = 1;
    localparam int CON_LO_N = 0;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [CON_W-1:0] CON_IDLE = 12'h3E3;

    localparam int NUM_DRV = 5;

    // Number of bus sources currently enabled.
    function automatic logic [2:0] count_drivers(input logic [NUM_DRV-1:0] en);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < NUM_DRV; i++) begin
            cnt = cnt + {2'b00, en[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/sap1_alu.sv
// SAP-1 adder/subtractor: purely combinational, modulo 2^DATA_W, no carry out.
module sap1_alu #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              su,
    output logic [DATA_W-1:0] y
);

    // Subtract selects A-B, otherwise A+B.
    always_comb begin
        if (su) begin
            y = a - b;
        end else begin
            y = a + b;
        end
    end

endmodule

// File: rtl/sap1_datapath.sv
// SAP-1 datapath: PC, MAR, 16x8 RAM, IR, A, B, OUT around a shared W-bus,
// steered by the sequencer's 12-bit control word.
module sap1_datapath
    import sap1_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [CON_W-1:0]  con,
    input  logic              prog_en,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [3:0]        opcode,
    output logic [DATA_W-1:0] out_port,
    output logic [DATA_W-1:0] wbus,
    output logic              bus_err,
    output logic              hlt,
    output logic [ADDR_W-1:0] pc
);

    localparam int RAM_D = 1 << ADDR_W;

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_mar;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_out;
    logic [DATA_W-1:0] r_ram [0:RAM_D-1];

    logic              w_ep;
    logic              w_ce;
    logic              w_ei;
    logic              w_ea;
    logic              w_eu;
    logic              w_run;
    logic [DATA_W-1:0] w_alu;
    logic [DATA_W-1:0] w_ram_rd;
    logic [DATA_W-1:0] w_bus;
    logic [NUM_DRV-1:0] w_drv;

    assign w_ep  = con[CON_EP];
    assign w_ce  = ~con[CON_CE_N];
    assign w_ei  = ~con[CON_EI_N];
    assign w_ea  = con[CON_EA];
    assign w_eu  = con[CON_EU];
    assign w_run = ~prog_en;

    assign w_ram_rd = r_ram[r_mar];

    sap1_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a  (r_a),
        .b  (r_b),
        .su (con[CON_SU]),
        .y  (w_alu)
    );

    // Wired-OR bus: idle reads zero, contention yields the OR of all enabled sources.
    always_comb begin
        w_bus = ({DATA_W{w_ep}} & {{(DATA_W-ADDR_W){1'b0}}, r_pc})
              | ({DATA_W{w_ce}} & w_ram_rd)
              | ({DATA_W{w_ei}} & {{(DATA_W-ADDR_W){1'b0}}, r_ir[ADDR_W-1:0]})
              | ({DATA_W{w_ea}} & r_a)
              | ({DATA_W{w_eu}} & w_alu);
        w_drv = {w_ep, w_ce, w_ei, w_ea, w_eu};
    end

    // Architectural registers; program mode freezes them while RAM is loaded.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc  <= '0;
            r_mar <= '0;
            r_ir  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_out <= '0;
        end else if (w_run) begin
            if (!con[CON_LM_N]) r_mar <= w_bus[ADDR_W-1:0];
            if (!con[CON_LI_N]) r_ir  <= w_bus;
            if (!con[CON_LA_N]) r_a   <= w_bus;
            if (!con[CON_LB_N]) r_b   <= w_bus;
            if (!con[CON_LO_N]) r_out <= w_bus;
            if (con[CON_CP])    r_pc  <= r_pc + ADDR_W'(1);
        end
    end

    // Program-load port; RAM keeps its contents across reset.
    always_ff @(posedge clock) begin
        if (prog_en && prog_we) begin
            r_ram[prog_addr] <= prog_data;
        end
    end

    assign wbus     = w_bus;
    assign bus_err  = (count_drivers(w_drv) > 3'd1);
    assign opcode   = r_ir[DATA_W-1:DATA_W-4];
    assign hlt      = (r_ir[DATA_W-1:DATA_W-4] == OP_HLT);
    assign out_port = r_out;
    assign pc       = r_pc;

endmodule

// File: tb/tb_sap1_datapath.sv
// Directed program run plus random control words for sap1_datapath,
// checked against a register-level reference model of the datapath.
module tb_sap1_datapath;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] con;
    logic        prog_en;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [7:0]  prog_data;
    logic [3:0]  opcode;
    logic [7:0]  out_port;
    logic [7:0]  wbus;
    logic        bus_err;
    logic        hlt;
    logic [3:0]  pc;

    int total = 0;
    int bad   = 0;

    // Reference state
    logic [7:0] m_ram [16];
    logic [3:0] m_pc, m_mar;
    logic [7:0] m_ir, m_a, m_b, m_out;

    sap1_datapath #(.ADDR_W(4), .DATA_W(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .con       (con),
        .prog_en   (prog_en),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .opcode    (opcode),
        .out_port  (out_port),
        .wbus      (wbus),
        .bus_err   (bus_err),
        .hlt       (hlt),
        .pc        (pc)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 4'h0; m_mar = 4'h0; m_ir = 8'h00; m_a = 8'h00; m_b = 8'h00; m_out = 8'h00;
    endtask

    // Expected bus value and contention flag for control word w and current model state.
    task automatic model_bus(input logic [11:0] w, output logic [7:0] b, output logic e);
        int n;
        logic [7:0] alu;
        alu = w[3] ? (m_a - m_b) : (m_a + m_b);
        b = 8'h00; n = 0;
        if (w[10])  begin b = b | {4'h0, m_pc};     n++; end
        if (!w[8])  begin b = b | m_ram[m_mar];     n++; end
        if (!w[6])  begin b = b | {4'h0, m_ir[3:0]}; n++; end
        if (w[4])   begin b = b | m_a;              n++; end
        if (w[2])   begin b = b | alu;              n++; end
        e = (n > 1);
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".opcode"}, opcode, m_ir[7:4]);
        chk({tag, ".out"}, out_port, m_out);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".hlt"}, hlt, (m_ir[7:4] == 4'hF));
    endtask

    // One clock with control word w; bus checked before the edge, registers after.
    task automatic step(input logic [11:0] w, input logic pe = 1'b0, input logic pw = 1'b0,
                        input logic [3:0] pa = 4'h0, input logic [7:0] pd = 8'h00);
        logic [7:0] b;
        logic       e;
        @(negedge clock);
        con = w; prog_en = pe; prog_we = pw; prog_addr = pa; prog_data = pd;
        #1;
        model_bus(w, b, e);
        chk("wbus", wbus, b);
        chk("bus_err", bus_err, e);
        @(posedge clock);
        if (pe) begin
            if (pw) m_ram[pa] = pd;
        end else begin
            if (!w[9]) m_mar = b[3:0];
            if (!w[7]) m_ir  = b;
            if (!w[5]) m_a   = b;
            if (!w[1]) m_b   = b;
            if (!w[0]) m_out = b;
            if (w[11]) m_pc  = m_pc + 4'd1;
        end
        #1;
        chk_regs("step");
    endtask

    task automatic fetch();
        step(12'h5E3); step(12'hBE3); step(12'h263);
    endtask
    task automatic ex_lda();
        step(12'h1A3); step(12'h2C3); step(12'h3E3);
    endtask
    task automatic ex_add();
        step(12'h1A3); step(12'h2E1); step(12'h3C7);
    endtask
    task automatic ex_sub();
        step(12'h1A3); step(12'h2E1); step(12'h3CF);
    endtask
    task automatic ex_out();
        step(12'h3F2); step(12'h3E3); step(12'h3E3);
    endtask
    task automatic read_a(input string tag, input logic [7:0] exp);
        step(12'h3F3);
        chk(tag, wbus, exp);
    endtask

    task automatic do_reset();
        @(negedge clock);
        con = 12'h3E3; prog_en = 1'b0; prog_we = 1'b0;
        reset = 1'b1;
        model_reset();
        #2;
        chk_regs("rst");
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] img [16];
        img = '{8'h09, 8'h1A, 8'h2A, 8'h1A, 8'hE0, 8'hF0, 8'h0B, 8'h2C,
                8'hE0, 8'h10, 8'h05, 8'h02, 8'h05, 8'h77, 8'h88, 8'h99};
        reset = 1'b1; con = 12'h3E3; prog_en = 1'b0; prog_we = 1'b0;
        prog_addr = 4'h0; prog_data = 8'h00;
        model_reset();
        #2;
        chk_regs("reset_async");
        #10;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk_regs("reset_state");
        chk("reset_idle_bus", wbus, 8'h00);

        for (int i = 0; i < 16; i++) step(12'h3E3, 1'b1, 1'b1, 4'(i), img[i]);

        // Fetch at PC=3
        repeat (3) step(12'hBE3);
        fetch();
        chk("fetch_pc", pc, 4'h4);
        chk("fetch_opcode", opcode, 4'h1);
        step(12'h2E3);
        chk("fetch_mar_ram", wbus, 8'h1A);

        do_reset();

        // Program run from address 0
        fetch(); ex_lda(); read_a("lda_a", 8'h10);
        fetch(); ex_add(); read_a("add_a", 8'h15);
        fetch(); ex_sub(); read_a("sub_a", 8'h10);
        fetch(); ex_add(); read_a("add2_a", 8'h15);
        fetch(); ex_out();
        chk("out_15", out_port, 8'h15);
        fetch();
        chk("hlt_set", hlt, 1'b1);
        fetch(); ex_lda(); read_a("lda_b_a", 8'h02);
        fetch(); ex_sub(); read_a("sub_neg_a", 8'hFD);
        fetch(); ex_out();
        chk("out_fd", out_port, 8'hFD);

        // Contention: PC and RAM[MAR] both driving
        step(12'h6E3);
        chk("contention_err", bus_err, 1'b1);

        // PC wrap
        while (m_pc != 4'hF) step(12'hBE3);
        step(12'hBE3);
        chk("pc_wrap", pc, 4'h0);

        // Program mode freezes PC/MAR and writes RAM
        step(12'h5E3, 1'b1, 1'b1, 4'h2, 8'h5A);
        step(12'hBE3, 1'b1, 1'b0, 4'h2, 8'hFF);
        chk("prog_pc_hold", pc, 4'h0);
        step(12'h2E3);
        chk("prog_mar_hold", wbus, 8'hE0);
        step(12'hBE3); step(12'hBE3); step(12'h5E3);
        step(12'h263, 1'b1, 1'b0, 4'h2, 8'hFF);
        step(12'h2E3);
        chk("prog_write", wbus, 8'h5A);

        // Reset between 5E3 and BE3
        step(12'h5E3);
        #2;
        con = 12'h3E3;
        reset = 1'b1;
        model_reset();
        #1;
        chk("midrst_pc", pc, 4'h0);
        chk("midrst_op", opcode, 4'h0);
        chk("midrst_out", out_port, 8'h00);
        chk("midrst_hlt", hlt, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        step(12'h2E3);
        chk("midrst_ram", wbus, 8'h09);

        // Random control words, occasional program-mode writes
        for (int i = 0; i < 300; i++) begin
            logic [31:0] r;
            r = $urandom;
            step(r[11:0], ($urandom_range(0, 7) == 0), r[12], r[19:16], r[31:24]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
